// File: rtl/tri_bus_arbiter_if.sv
// Bus-side handshake bundle for tri_bus_arbiter: requests in, grant/enable/owner status out.
interface tri_bus_arbiter_if #(
  parameter int N     = 4,
  parameter int IDX_W = 2
);
  logic [N-1:0]     Req;
  logic [N-1:0]     Grant;
  logic [N-1:0]     OE;
  logic [IDX_W-1:0] Owner;
  logic             Busy;
  logic             Preempt;

  modport master (input Req, output Grant, OE, Owner, Busy, Preempt);
  modport slave  (output Req, input Grant, OE, Owner, Busy, Preempt);
endinterface

// File: rtl/tri_bus_arbiter.sv
// Round-robin tristate bus arbiter with setup and turnaround cycles so enables never overlap.
// Optional forced release after MAX_HOLD drive cycles when BUS_TIMEOUT_EN is defined.
module tri_bus_arbiter #(
  parameter int N           = 4,
  parameter int IDX_W       = 2,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  tri_bus_arbiter_if.master bus
);

  localparam logic [1:0]       ST_IDLE   = 2'd0;
  localparam logic [1:0]       ST_SETUP  = 2'd1;
  localparam logic [1:0]       ST_DRIVE  = 2'd2;
  localparam logic [1:0]       ST_TURN   = 2'd3;
  localparam logic [3:0]       TURN_LOAD = 4'(TURN_CYCLES);
  localparam logic [IDX_W:0]   N_EXT     = (IDX_W+1)'(N);
  localparam logic [N-1:0]     ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};

  if (IDX_W != $clog2(N) || N < 2 || N > 16 || TURN_CYCLES < 1 || TURN_CYCLES > 15 ||
      MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_param
    $error("tri_bus_arbiter: illegal parameter set");
  end

  logic [1:0]       state_r;
  logic [N-1:0]     grant_r;
  logic [N-1:0]     oe_r;
  logic [IDX_W-1:0] owner_r;
  logic             busy_r;
  logic [IDX_W-1:0] ptr_r;
  logic [3:0]       turn_r;

  logic             win_found_s;
  logic [IDX_W-1:0] win_idx_s;
  logic [IDX_W:0]   cand_s;
  logic [IDX_W:0]   ptr_nxt_s;
  logic [N-1:0]     win_oh_s;
  logic [N-1:0]     owner_oh_s;
  logic             owner_req_s;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [7:0] HOLD_SAT  = 8'(MAX_HOLD);
  logic [7:0] hold_r;
  logic       preempt_r;
  logic       compete_s;
`endif

  // Round-robin search: first request at or above the pointer, wrapping modulo N.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int i = 0; i < N; i++) begin
      cand_s = {1'b0, ptr_r} + (IDX_W+1)'(i);
      if (cand_s >= N_EXT) begin
        cand_s = cand_s - N_EXT;
      end else begin
        cand_s = cand_s;
      end
      if (!win_found_s && bus.Req[cand_s[IDX_W-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s[IDX_W-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Pointer advance past the winner and one-hot decodes of winner and owner.
  always_comb begin
    ptr_nxt_s = {1'b0, win_idx_s} + {{IDX_W{1'b0}}, 1'b1};
    if (ptr_nxt_s >= N_EXT) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = ptr_nxt_s;
    end
    win_oh_s    = ONE_HOT0 << win_idx_s;
    owner_oh_s  = ONE_HOT0 << owner_r;
    owner_req_s = bus.Req[owner_r];
  end

`ifdef BUS_TIMEOUT_EN
  // A competing request is any active request other than the owner's.
  always_comb begin
    compete_s = ((bus.Req & ~owner_oh_s) != '0);
  end
`endif

  // Arbiter state machine; all bus-facing outputs are registered here.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      grant_r <= '0;
      oe_r    <= '0;
      owner_r <= '0;
      busy_r  <= 1'b0;
      ptr_r   <= '0;
      turn_r  <= 4'd0;
`ifdef BUS_TIMEOUT_EN
      hold_r    <= 8'd0;
      preempt_r <= 1'b0;
`endif
    end else begin
`ifdef BUS_TIMEOUT_EN
      preempt_r <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (win_found_s) begin
            state_r <= ST_SETUP;
            grant_r <= win_oh_s;
            owner_r <= win_idx_s;
            ptr_r   <= ptr_nxt_s[IDX_W-1:0];
            busy_r  <= 1'b1;
          end else begin
            grant_r <= '0;
            oe_r    <= '0;
            busy_r  <= 1'b0;
          end
        end
        ST_SETUP: begin
          // Owner withdrew before driving: the bus was never enabled, so skip turnaround.
          if (owner_req_s) begin
            state_r <= ST_DRIVE;
            oe_r    <= owner_oh_s;
`ifdef BUS_TIMEOUT_EN
            hold_r  <= 8'd0;
`endif
          end else begin
            state_r <= ST_IDLE;
            grant_r <= '0;
            busy_r  <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (!owner_req_s) begin
            state_r <= ST_TURN;
            grant_r <= '0;
            oe_r    <= '0;
            turn_r  <= TURN_LOAD;
`ifdef BUS_TIMEOUT_EN
          end else if (hold_r >= HOLD_LAST && compete_s) begin
            state_r   <= ST_TURN;
            grant_r   <= '0;
            oe_r      <= '0;
            turn_r    <= TURN_LOAD;
            preempt_r <= 1'b1;
          end else if (hold_r < HOLD_SAT) begin
            hold_r <= hold_r + 8'd1;
`endif
          end else begin
            state_r <= ST_DRIVE;
          end
        end
        ST_TURN: begin
          turn_r <= turn_r - 4'd1;
          if (turn_r <= 4'd1) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_TURN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          grant_r <= '0;
          oe_r    <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Grant = grant_r;
  assign bus.OE    = oe_r;
  assign bus.Owner = owner_r;
  assign bus.Busy  = busy_r;
`ifdef BUS_TIMEOUT_EN
  assign bus.Preempt = preempt_r;
`else
  assign bus.Preempt = 1'b0;
`endif

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Self-checking bench for tri_bus_arbiter: table-driven vectors through a scoreboard queue,
// plus a hand-written timeout sequence whose expectations follow BUS_TIMEOUT_EN.
module tb_tri_bus_arbiter;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  tri_bus_arbiter_if #(.N(4), .IDX_W(2)) bus ();

  tri_bus_arbiter #(
    .N(4), .IDX_W(2), .TURN_CYCLES(1), .MAX_HOLD(4)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] oe;
    logic [1:0] owner;
    logic       busy;
    logic       pre;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(input logic rst, input logic [3:0] req, input logic [3:0] grant,
                              input logic [3:0] oe, input logic [1:0] owner,
                              input logic busy, input logic pre);
    vec_t v;
    v.rst = rst; v.req = req; v.grant = grant; v.oe = oe;
    v.owner = owner; v.busy = busy; v.pre = pre;
    tbl.push_back(v);
  endfunction

  task automatic step(input vec_t v, input string tag);
    vec_t e;
    logic ok;
    @(negedge Clk);
    Reset   = v.rst;
    bus.Req = v.req;
    exp_q.push_back(v);
    @(posedge Clk);
    #1;
    e  = exp_q.pop_front();
    ok = (bus.Grant === e.grant) && (bus.OE === e.oe) && (bus.Busy === e.busy) &&
         (bus.Preempt === e.pre);
    if (e.busy || e.rst) ok = ok && (bus.Owner === e.owner);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s vec %0d: got grant=%b oe=%b owner=%0d busy=%b pre=%b, want grant=%b oe=%b owner=%0d busy=%b pre=%b",
               tag, n_vec, bus.Grant, bus.OE, bus.Owner, bus.Busy, bus.Preempt,
               e.grant, e.oe, e.owner, e.busy, e.pre);
    end
    if (($countones(bus.OE) > 1) || ((bus.OE & ~bus.Grant) != 4'b0000)) begin
      n_bad++;
      $display("FAIL oe_invariant vec %0d: got oe=%b grant=%b, want one-hot oe within grant",
               n_vec, bus.OE, bus.Grant);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [3:0] grant,
                              input logic [3:0] oe, input logic [1:0] owner,
                              input logic busy, input logic pre);
    vec_t v;
    v.rst = rst; v.req = req; v.grant = grant; v.oe = oe;
    v.owner = owner; v.busy = busy; v.pre = pre;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] oh;
    Reset   = 1'b1;
    bus.Req = 4'b0000;

    // reset held two cycles, nothing requested
    add(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    // single requester 2: grant next edge, OE the edge after, one turnaround cycle
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(1'b0, 4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    // one-cycle pulse on Req[1] with pointer at 3: SETUP only, back to IDLE without TURN
    add(1'b0, 4'b0010, 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    // all four requesting, each owner drops for one cycle after three DRIVE cycles
    add(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int o = 0; o < 4; o++) begin
      oh = 4'b0001 << o;
      add(1'b0, 4'b1111, oh, 4'b0000, 2'(o), 1'b1, 1'b0);
      for (int d = 0; d < 3; d++) add(1'b0, 4'b1111, oh, oh, 2'(o), 1'b1, 1'b0);
      add(1'b0, 4'b1111 & ~oh, 4'b0000, 4'b0000, 2'(o), 1'b1, 1'b0);
      add(1'b0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    end
    add(1'b0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    // reset during DRIVE with owner 2 clears pointer: next grant goes to index 0
    add(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(1'b0, 4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0);
    add(1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(1'b1, 4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(1'b0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], "tbl");

    // owner 0 holds; requester 3 competes after two DRIVE cycles (MAX_HOLD=4)
    step(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0), "hold_rst");
    step(mk(1'b0, 4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0), "hold_setup");
    step(mk(1'b0, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0), "hold_drive");
    step(mk(1'b0, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0), "hold_drive");
    step(mk(1'b0, 4'b1001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0), "hold_drive");
    step(mk(1'b0, 4'b1001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0), "hold_drive");
`ifdef BUS_TIMEOUT_EN
    step(mk(1'b0, 4'b1001, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b1), "preempt");
    step(mk(1'b0, 4'b1001, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0), "preempt_idle");
    step(mk(1'b0, 4'b1001, 4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0), "preempt_regrant");
`else
    step(mk(1'b0, 4'b1001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0), "no_preempt");
    step(mk(1'b0, 4'b1001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0), "no_preempt");
    step(mk(1'b0, 4'b1001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0), "no_preempt");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tri_bus_arbiter.md
Name: tri_bus_arbiter

Overview:
Round-robin arbiter that shares one tristate bus among N drivers. It issues a one-hot grant and a separate, registered per-requester output enable, and inserts a setup cycle and turnaround idle cycles so that no two enables ever overlap. It sits beside `tri`/`pullup` nets and drives the `OE ? data : 'hz` select on each driver's `assign`.

Parameters:
- N, 4, number of requesters (2..16).
- IDX_W, 2, width of owner index; must equal clog2(N).
- TURN_CYCLES, 1, idle cycles with all OE low after a driver releases (1..15).
- MAX_HOLD, 16, DRIVE cycles before forced release when BUS_TIMEOUT_EN is defined (1..255).

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high.
- Req  in  N  per-requester bus request; held high while the requester wants the bus.
- Grant  out  N  one-hot registered grant; all zero when no owner.
- OE  out  N  one-hot registered tristate enable; a subset of Grant.
- Owner  out  IDX_W  index of current grantee; valid when Busy=1.
- Busy  out  1  high in SETUP, DRIVE or TURN.
- Preempt  out  1  one-cycle pulse on forced release; tied 0 without BUS_TIMEOUT_EN.

Behaviour:
Interface:
- One clock; reset is synchronous and active-high.
- Clock port is Clk; reset port is Reset.
- Reset sampled high at an edge forces the following, regardless of state:
  - state IDLE
  - Grant=0, OE=0, Owner=0, Busy=0, Preempt=0
  - RR pointer=0
  - turnaround and hold counters=0

States:
- IDLE: Grant=0, OE=0, Busy=0.
  - If Req!=0, pick the winner: the first set bit at or above pointer P, wrapping modulo N.
  - Next edge: Grant[winner]=1, Owner=winner, P=(winner+1) mod N, go to SETUP.
- SETUP: exactly 1 cycle, Grant set, OE=0. This is the bus settle cycle.
  - If Req[Owner]=1, go to DRIVE and OE[Owner]=1 at the next edge.
  - If Req[Owner]=0, go to IDLE and Grant=0. The bus was never driven, so no turnaround.
- DRIVE: Grant=OE=one-hot(Owner).
  - When Req[Owner]=0 is sampled, Grant=0 and OE=0 at the next edge; load the turnaround counter with TURN_CYCLES and go to TURN.
- TURN: Grant=0, OE=0, Busy=1.
  - Decrement the counter each cycle.
  - When it reaches 0, go to IDLE.
  - New arbitration happens only from IDLE.

Timing and rules:
- Latency: Req rising, first sampled high at edge k in IDLE, gives Grant at k+1 and OE at k+2.
- Minimum gap between one driver's OE falling and another's rising is TURN_CYCLES+2 edges (TURN, IDLE, SETUP).
- Requests other than the owner's are ignored outside IDLE. There is no queueing beyond level-held Req.
- Req may drop without a grant; there is no penalty.
- Simultaneous requests are resolved only by the RR pointer, with no fixed priority.
- Invariant: popcount(OE)<=1 and OE&~Grant==0 in every cycle.

Optional Feature:
BUS_TIMEOUT_EN:
- Defined: a hold counter clears on entry to DRIVE and increments each DRIVE cycle.
  - When it reaches MAX_HOLD and (Req & ~one-hot(Owner))!=0, the arbiter forces DRIVE to TURN exactly as on a release.
  - Preempt=1 for that one cycle.
  - The preempted requester may keep Req high and is re-arbitrated under round-robin.
  - With no competing request, the owner keeps the bus past MAX_HOLD.
- Undefined: no hold counter; the owner holds the bus indefinitely; Preempt is constant 0.

Test Plan:
1. Reset held 2 cycles, Req=4'b0000 → Grant=OE=0, Busy=0, Owner=0 throughout.
2. Req=4'b0100 from edge 10 until edge 20 → Grant=4'b0100 at edge 11, OE=4'b0100 at edges 12..20, OE=0 at edge 21, Busy=0 at edge 22 (TURN_CYCLES=1).
3. Req=4'b1111 held continuously, each owner drops Req for 1 cycle after 3 DRIVE cycles → grant order 0,1,2,3,0; popcount(OE)<=1 every cycle; OE gap between owners ≥3 edges.
4. Req[1] pulsed for exactly 1 cycle in IDLE → Grant=4'b0010 for one SETUP cycle, then IDLE; OE stays 0; no TURN cycles.
5. Reset asserted for 1 cycle during DRIVE with Owner=2 → next edge Grant=OE=0, Busy=0; next arbitration with Req=4'b1111 grants index 0.
6. BUS_TIMEOUT_EN, MAX_HOLD=4, Req[0] held and Req[3] raised after 2 DRIVE cycles → Preempt=1 after 4th DRIVE cycle, OE[0] falls, Grant=4'b1000 after TURN+IDLE; without the macro, OE[0] stays high and Preempt stays 0.
